// File: rtl/dly_lane_programmer.sv
// Byte-lane delay-load initiator.
// Streams a 32x8 delay table into one lane, then pulses set.
module dly_lane_programmer #(
  parameter int NUM_LANES = 2,
  parameter int LD_GAP    = 0,
  parameter int SET_DLY   = 2,
  localparam int LSW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_div,
  input  logic                 rst_n,
  input  logic                 tbl_we,
  input  logic [4:0]           tbl_addr,
  input  logic [7:0]           tbl_data,
  input  logic                 start,
  input  logic                 run_all,
  input  logic [LSW-1:0]       lane_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_reject,
  output logic [7:0]           dly_data,
  output logic [4:0]           dly_addr,
  output logic [NUM_LANES-1:0] ld_delay,
  output logic                 set
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_GAP,
    S_SETW,
    S_SET
  } state_t;

  localparam logic [3:0] GAP_LD =
    4'(LD_GAP > 0 ? LD_GAP - 1 : 0);
  localparam logic [3:0] SET_LD =
    4'(SET_DLY > 0 ? SET_DLY - 1 : 0);

  state_t state_q, state_d;
  logic [5:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       all_q, all_d;
  logic [LSW-1:0] lane_q, lane_d;

  logic [7:0]  tbl_q [32];
  logic [31:0] dirty_q;

  logic [4:0] idx;
  logic       hit;
  logic       clr;
  logic       wr_ok;
  logic       rej_d;

  logic [NUM_LANES-1:0] ld_d;
  logic [7:0] data_d;
  logic [4:0] addr_d;
  logic       set_d;
  logic       done_d;
  logic       busy_d;

  state_t     end_st;
  logic [3:0] end_cnt;

  function automatic logic valid_addr(
    input logic [4:0] a
  );
    return (a <= 5'd9) ||
           ((a >= 5'd16) && (a <= 5'd24));
  endfunction

  assign idx   = ptr_q[4:0];
  assign wr_ok = tbl_we &&
                 (state_q == S_IDLE) && !start;
  assign rej_d = tbl_we && !wr_ok;

  // Where to go once the whole table has been scanned.
  always_comb begin
    end_st  = (SET_DLY > 0) ? S_SETW : S_SET;
    end_cnt = SET_LD;
  end

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    all_d   = all_q;
    lane_d  = lane_q;
    ld_d    = '0;
    data_d  = dly_data;
    addr_d  = dly_addr;
    set_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy;
    clr     = 1'b0;
    hit     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          all_d   = run_all;
          lane_d  = lane_sel;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        hit = valid_addr(idx) &&
              (all_q || dirty_q[idx]);
        ptr_d = ptr_q + 6'd1;
        if (hit) begin
          for (int i = 0; i < NUM_LANES; i++)
            ld_d[i] = (lane_q == LSW'(i));
          addr_d = idx;
          data_d = tbl_q[idx];
          clr    = 1'b1;
        end
        if (hit && (LD_GAP > 0)) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else if (idx == 5'd31) begin
          state_d = end_st;
          cnt_d   = end_cnt;
        end
      end
      S_GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (ptr_q[5]) begin
          state_d = end_st;
          cnt_d   = end_cnt;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SETW: begin
        if (cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
        else
          state_d = S_SET;
      end
      S_SET: begin
        set_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      all_q     <= 1'b0;
      lane_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_reject <= 1'b0;
      dly_data  <= '0;
      dly_addr  <= '0;
      ld_delay  <= '0;
      set       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      all_q     <= all_d;
      lane_q    <= lane_d;
      busy      <= busy_d;
      done      <= done_d;
      wr_reject <= rej_d;
      dly_data  <= data_d;
      dly_addr  <= addr_d;
      ld_delay  <= ld_d;
      set       <= set_d;
    end
  end

  // Delay table and dirty tracking; writes only land while idle.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        tbl_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_ok) begin
        tbl_q[tbl_addr]   <= tbl_data;
        dirty_q[tbl_addr] <= valid_addr(tbl_addr);
      end
      if (clr)
        dirty_q[idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dly_lane_programmer.sv
// Scoreboard bench for dly_lane_programmer.
// Two instances: default timing and LD_GAP=3.
module tb_dly_lane_programmer;

  typedef struct packed {
    logic [1:0] ld;
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0;
  logic       tbl_we = 1'b0;
  logic [4:0] tbl_addr = '0;
  logic [7:0] tbl_data = '0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       run_all = 1'b0;
  logic [0:0] lane_sel = '0;

  logic       busy1, done1, rej1, set1;
  logic [7:0] data1;
  logic [4:0] addr1;
  logic [1:0] ld1;
  logic       busy2, done2, rej2, set2;
  logic [7:0] data2;
  logic [4:0] addr2;
  logic [1:0] ld2;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_tbl [32];
  bit         m_dirty [32];
  exp_t       sb [$];

  always #5 clk_div = ~clk_div;

  dly_lane_programmer #(
    .NUM_LANES(2), .LD_GAP(0), .SET_DLY(2)
  ) dut1 (
    .clk_div(clk_div), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .start(start1),
    .run_all(run_all), .lane_sel(lane_sel),
    .busy(busy1), .done(done1),
    .wr_reject(rej1), .dly_data(data1),
    .dly_addr(addr1), .ld_delay(ld1),
    .set(set1)
  );

  dly_lane_programmer #(
    .NUM_LANES(2), .LD_GAP(3), .SET_DLY(2)
  ) dut2 (
    .clk_div(clk_div), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .start(start2),
    .run_all(run_all), .lane_sel(lane_sel),
    .busy(busy2), .done(done2),
    .wr_reject(rej2), .dly_data(data2),
    .dly_addr(addr2), .ld_delay(ld2),
    .set(set2)
  );

  function automatic bit vld(input int a);
    return (a <= 9) || (a >= 16 && a <= 24);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_tbl[i] = '0;
      m_dirty[i] = 0;
    end
    sb.delete();
  endtask

  task automatic write_tbl(input int a, input logic [7:0] d);
    tbl_we = 1'b1;
    tbl_addr = 5'(a);
    tbl_data = d;
    @(posedge clk_div); #1;
    tbl_we = 1'b0;
    m_tbl[a] = d;
    if (vld(a)) m_dirty[a] = 1;
  endtask

  task automatic write_all();
    for (int i = 0; i < 32; i++)
      write_tbl(i, 8'h40 + 8'(i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tbl_we = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_div);
    #1;
    rst_n = 1'b1;
    @(posedge clk_div); #1;
  endtask

  // Runs one sequence; inj>0 pokes a write+start at that cycle.
  task automatic run(input bit g, input bit all,
                     input bit lane, input int inj);
    int nsel, n, last, rej, exp_len;
    bit got;
    exp_t e;
    logic [1:0] o_ld;
    logic [4:0] o_addr;
    logic [7:0] o_data;
    logic o_set, o_done, o_busy, o_rej;
    nsel = 0;
    for (int a = 0; a < 32; a++) begin
      if (vld(a) && (all || m_dirty[a])) begin
        e.ld = lane ? 2'b10 : 2'b01;
        e.addr = 5'(a);
        e.data = m_tbl[a];
        sb.push_back(e);
        m_dirty[a] = 0;
        nsel++;
      end
    end
    exp_len = 32 + nsel * (g ? 3 : 0) + 2 + 1;
    run_all = all;
    lane_sel = lane;
    if (g) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk_div); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    n = 0; last = -100; rej = 0; got = 0;
    while (!got && n < 400) begin
      @(posedge clk_div); #1;
      n++;
      tbl_we = 1'b0;
      start1 = 1'b0;
      o_ld   = g ? ld2   : ld1;
      o_addr = g ? addr2 : addr1;
      o_data = g ? data2 : data1;
      o_set  = g ? set2  : set1;
      o_done = g ? done2 : done1;
      o_busy = g ? busy2 : busy1;
      o_rej  = g ? rej2  : rej1;
      if (o_rej) rej++;
      if (o_ld !== 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pulse_extra n=%0d got addr=%0d ld=%b want none",
                   n, o_addr, o_ld);
        end else begin
          e = sb.pop_front();
          if (o_ld !== e.ld || o_addr !== e.addr ||
              o_data !== e.data) begin
            failures++;
            $display("FAIL pulse n=%0d got ld=%b a=%0d d=%h want ld=%b a=%0d d=%h",
                     n, o_ld, o_addr, o_data, e.ld, e.addr, e.data);
          end
        end
        if (g) begin
          checks++;
          if (n - last < 4) begin
            failures++;
            $display("FAIL gap_spacing got %0d want >=4", n - last);
          end
        end
        last = n;
      end
      if (o_set) begin
        checks++;
        if (o_ld !== 2'b00 || o_done !== 1'b1) begin
          failures++;
          $display("FAIL set_align got ld=%b done=%b want ld=00 done=1",
                   o_ld, o_done);
        end
      end
      if (o_done) begin
        got = 1;
        checks++;
        if (n !== exp_len || o_set !== 1'b1 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL run_len got n=%0d set=%b busy=%b want n=%0d set=1 busy=0",
                   n, o_set, o_busy, exp_len);
        end
      end else begin
        checks++;
        if (o_busy !== 1'b1) begin
          failures++;
          $display("FAIL busy n=%0d got %b want 1", n, o_busy);
        end
      end
      if (n == inj) begin
        tbl_we = 1'b1;
        tbl_addr = 5'd5;
        tbl_data = 8'hFF;
        start1 = 1'b1;
        run_all = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL run_timeout got no done want done");
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pulses_missing got %0d left want 0", sb.size());
      sb.delete();
    end
    checks++;
    if (rej !== ((inj > 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL wr_reject_cnt got %0d want %0d",
               rej, (inj > 0) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy1, done1, rej1, set1, data1, addr1, ld1} !== '0) begin
      failures++;
      $display("FAIL reset_outs got %b want 0",
               {busy1, done1, rej1, set1, data1, addr1, ld1});
    end
    checks++;
    if ({busy2, done2, rej2, set2, data2, addr2, ld2} !== '0) begin
      failures++;
      $display("FAIL reset_outs2 got %b want 0",
               {busy2, done2, rej2, set2, data2, addr2, ld2});
    end
  endtask

  task automatic test_run_all();
    do_reset();
    write_all();
    run(0, 1, 1, -1);
  endtask

  task automatic test_dirty();
    write_tbl(3, 8'hA3);
    write_tbl(20, 8'hB4);
    run(0, 0, 0, -1);
    run(0, 0, 0, -1);
  endtask

  task automatic test_busy();
    bit extra;
    run(0, 1, 0, 10);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_div); #1;
      if (busy1 || ld1 !== 2'b00) extra = 1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL second_run got activity want idle");
    end
    run(0, 1, 1, -1);
  endtask

  task automatic test_invalid();
    write_tbl(12, 8'h99);
    run(0, 0, 0, -1);
    run(0, 1, 0, -1);
  endtask

  task automatic test_gap();
    do_reset();
    write_all();
    run(1, 1, 1, -1);
  endtask

  task automatic test_reset_mid();
    int cnt, n;
    do_reset();
    write_all();
    run_all = 1'b1;
    lane_sel = 1'b0;
    start1 = 1'b1;
    @(posedge clk_div); #1;
    start1 = 1'b0;
    cnt = 0; n = 0;
    while (cnt < 5 && n < 50) begin
      @(posedge clk_div); #1;
      n++;
      if (ld1 !== 2'b00) cnt++;
    end
    checks++;
    if (cnt != 5) begin
      failures++;
      $display("FAIL mid_pulses got %0d want 5", cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, rej1, set1, data1, addr1, ld1} !== '0) begin
      failures++;
      $display("FAIL mid_reset got %b want 0",
               {busy1, done1, rej1, set1, data1, addr1, ld1});
    end
    model_clear();
    @(posedge clk_div); #1;
    rst_n = 1'b1;
    @(posedge clk_div); #1;
    run(0, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_run_all();
    test_dirty();
    test_busy();
    test_invalid();
    test_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
